// File: rtl/ahb_lite_mux_pkg.sv
// rtl/ahb_lite_mux_pkg.sv - shared AHB-Lite encodings and decoder region constants
package ahb_lite_mux_pkg;

    localparam int NUM_SLAVES = 4;
    localparam int DATA_W     = 32;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [DATA_W-1:0] DEFAULT_HRDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Decoder region field is HADDR[REGION_MSB:REGION_LSB].
    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;

    localparam logic [3:0] REGION_S0 = 4'h0;
    localparam logic [3:0] REGION_S1 = 4'h1;
    localparam logic [3:0] REGION_S2 = 4'h2;
    localparam logic [3:0] REGION_S3 = 4'h3;

    function automatic logic [NUM_SLAVES-1:0] region_to_hsel(input logic [3:0] region);
        logic [NUM_SLAVES-1:0] sel;
        sel = '0;
        case (region)
            REGION_S0: sel = 4'b0001;
            REGION_S1: sel = 4'b0010;
            REGION_S2: sel = 4'b0100;
            REGION_S3: sel = 4'b1000;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ahb_lite_sel_prio.sv
// rtl/ahb_lite_sel_prio.sv - 4-bit lowest-index-wins one-hot priority encoder
module ahb_lite_sel_prio
    import ahb_lite_mux_pkg::*;
(
    input  logic [NUM_SLAVES-1:0] req,
    output logic [NUM_SLAVES-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[0])      grant = 4'b0001;
        else if (req[1]) grant = 4'b0010;
        else if (req[2]) grant = 4'b0100;
        else if (req[3]) grant = 4'b1000;
    end

endmodule

// File: rtl/ahb_lite_mux.sv
// rtl/ahb_lite_mux.sv - AHB-Lite four-slave response mux with data-phase select register
module ahb_lite_mux
    import ahb_lite_mux_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL0,
    input  logic              HSEL1,
    input  logic              HSEL2,
    input  logic              HSEL3,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HRESP,
    output logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA0,
    input  logic              HRESP0,
    input  logic              HREADYOUT0,
    input  logic [DATA_W-1:0] HRDATA1,
    input  logic              HRESP1,
    input  logic              HREADYOUT1,
    input  logic [DATA_W-1:0] HRDATA2,
    input  logic              HRESP2,
    input  logic              HREADYOUT2,
    input  logic [DATA_W-1:0] HRDATA3,
    input  logic              HRESP3,
    input  logic              HREADYOUT3
);

    logic [NUM_SLAVES-1:0] hsel_vec;
    logic [NUM_SLAVES-1:0] hsel_onehot;
    logic [NUM_SLAVES-1:0] dsel;

    assign hsel_vec = {HSEL3, HSEL2, HSEL1, HSEL0};

    ahb_lite_sel_prio u_sel_prio (
        .req   (hsel_vec),
        .grant (hsel_onehot)
    );

    // A stalled data phase keeps its owner until the bus-wide ready returns.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '0;
        end else if (HREADY) begin
            dsel <= hsel_onehot;
        end
    end

    // dsel == 0 is the default slave: zero data, OKAY, never stalls.
    always_comb begin
        HRDATA = DEFAULT_HRDATA;
        HRESP  = HRESP_OKAY;
        HREADY = 1'b1;
        case (dsel)
            4'b0001: begin
                HRDATA = HRDATA0;
                HRESP  = HRESP0;
                HREADY = HREADYOUT0;
            end
            4'b0010: begin
                HRDATA = HRDATA1;
                HRESP  = HRESP1;
                HREADY = HREADYOUT1;
            end
            4'b0100: begin
                HRDATA = HRDATA2;
                HRESP  = HRESP2;
                HREADY = HREADYOUT2;
            end
            4'b1000: begin
                HRDATA = HRDATA3;
                HRESP  = HRESP3;
                HREADY = HREADYOUT3;
            end
            default: begin
                HRDATA = DEFAULT_HRDATA;
                HRESP  = HRESP_OKAY;
                HREADY = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_lite_mux.sv
// tb/tb_ahb_lite_mux.sv - randomized and directed checks of ahb_lite_mux against an owner-index model
module tb_ahb_lite_mux;
    import ahb_lite_mux_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [3:0]  hsel = 4'hF;
    logic [31:0] srdata [4];
    logic        sresp  [4];
    logic        sready [4];
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        HREADY;

    int total = 0;
    int bad   = 0;
    int owner = -1;

    always #5 HCLK = ~HCLK;

    ahb_lite_mux dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL0      (hsel[0]),
        .HSEL1      (hsel[1]),
        .HSEL2      (hsel[2]),
        .HSEL3      (hsel[3]),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .HREADY     (HREADY),
        .HRDATA0    (srdata[0]),
        .HRESP0     (sresp[0]),
        .HREADYOUT0 (sready[0]),
        .HRDATA1    (srdata[1]),
        .HRESP1     (sresp[1]),
        .HREADYOUT1 (sready[1]),
        .HRDATA2    (srdata[2]),
        .HRESP2     (sresp[2]),
        .HREADYOUT2 (sready[2]),
        .HRDATA3    (srdata[3]),
        .HRESP3     (sresp[3]),
        .HREADYOUT3 (sready[3])
    );

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] decode(input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        return region_to_hsel(a[31:28]);
    endfunction

    // Owner of the data phase: -1 is the default slave.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) owner = -1;
        else if (owner < 0 || sready[owner[1:0]]) owner = lowest(hsel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        if (owner < 0) begin
            chk("model_hrdata", HRDATA, 32'h0);
            chk("model_hresp", {31'b0, HRESP}, 32'h0);
            chk("model_hready", {31'b0, HREADY}, 32'h1);
        end else begin
            chk("model_hrdata", HRDATA, srdata[owner[1:0]]);
            chk("model_hresp", {31'b0, HRESP}, {31'b0, sresp[owner[1:0]]});
            chk("model_hready", {31'b0, HREADY}, {31'b0, sready[owner[1:0]]});
        end
    end

    task automatic next();
        @(posedge HCLK);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] d, input logic r, input logic rdy);
        chk({name, "_hrdata"}, HRDATA, d);
        chk({name, "_hresp"}, {31'b0, HRESP}, {31'b0, r});
        chk({name, "_hready"}, {31'b0, HREADY}, {31'b0, rdy});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            srdata[i] = 32'hDEAD;
            sresp[i]  = 1'b1;
            sready[i] = 1'b0;
        end
        repeat (3) @(posedge HCLK);
        #1;
        hsel = 4'b0101;
        #3;
        lit("reset", 32'h0, 1'b0, 1'b1);

        next();
        HRESETn = 1'b1;
        hsel = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            srdata[i] = 32'h0;
            sresp[i]  = 1'b0;
            sready[i] = 1'b1;
        end
        next();

        hsel = decode(32'h1000_0001);
        srdata[1] = 32'hBB;
        next();
        hsel = 4'b0000;
        #3;
        lit("write_s1", 32'hBB, 1'b0, 1'b1);

        next();
        hsel = decode(32'h0000_0004);
        srdata[0] = 32'hAA;
        srdata[1] = 32'hCC;
        next();
        hsel = decode(32'h1000_0005);
        #3;
        lit("alt_s0", 32'hAA, 1'b0, 1'b1);
        next();
        hsel = 4'b0000;
        #3;
        lit("alt_s1", 32'hCC, 1'b0, 1'b1);

        next();
        hsel = decode(32'h0000_0008);
        next();
        hsel = decode(32'h1000_0008);
        sready[0] = 1'b0;
        #3;
        lit("wait1", 32'hAA, 1'b0, 1'b0);
        next();
        #3;
        lit("wait2", 32'hAA, 1'b0, 1'b0);
        next();
        sready[0] = 1'b1;
        #3;
        lit("wait_release", 32'hAA, 1'b0, 1'b1);
        next();
        #3;
        lit("after_wait_s1", 32'hCC, 1'b0, 1'b1);

        next();
        hsel = decode(32'h5000_0000);
        sresp[1]  = 1'b1;
        sready[1] = 1'b0;
        #3;
        lit("err1", 32'hCC, 1'b1, 1'b0);
        next();
        sready[1] = 1'b1;
        #3;
        lit("err2", 32'hCC, 1'b1, 1'b1);
        next();
        #3;
        lit("unmapped", 32'h0, 1'b0, 1'b1);

        hsel = 4'b0101;
        srdata[0] = 32'h11; sresp[0] = 1'b0; sready[0] = 1'b1;
        srdata[2] = 32'h22; sresp[2] = 1'b1; sready[2] = 1'b0;
        next();
        hsel = 4'b0000;
        #3;
        lit("illegal", 32'h11, 1'b0, 1'b1);

        next();
        hsel = 4'b0001;
        next();
        hsel = 4'b0000;
        sready[0] = 1'b0;
        #1;
        lit("pre_reset_stall", 32'h11, 1'b0, 1'b0);
        HRESETn = 1'b0;
        #1;
        lit("async_reset", 32'h0, 1'b0, 1'b1);
        next();
        next();
        HRESETn = 1'b1;
        hsel = 4'b0100;
        #2;
        lit("post_reset", 32'h0, 1'b0, 1'b1);

        repeat (3000) begin
            next();
            case ($urandom_range(0, 7))
                0, 1, 2: hsel = 4'b0000;
                3, 4, 5: hsel = 4'(1 << $urandom_range(0, 3));
                default: hsel = 4'($urandom);
            endcase
            for (int i = 0; i < 4; i++) begin
                srdata[i] = $urandom;
                sresp[i]  = ($urandom_range(0, 3) == 0);
                sready[i] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 HRESETn = 1'b0;
                #1 HRESETn = 1'b1;
            end
        end

        next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
